// File: rtl/vx_kmu_task_gen.sv
// ---------------------------------------------------------------------------
// vx_kmu_task_gen
//
// Kernel launch task generator. Software programs the kernel PC, the argument
// pointer and a 3-D grid through DCR writes, then writes the START slot. The
// block then emits one task descriptor per grid block, x fastest, then y,
// then z. It uses a valid/ready handshake and can sustain one task per cycle.
// Afterwards it pulses done for one cycle.
//
// Parameters
//   DCR_BASE  DCR address of slot 0 (PC); slots 1..5 are ARG, GRID_X,
//             GRID_Y, GRID_Z and START.
//   DIM_W     width of each grid dimension and block index.
//
// Ports
//   clk, reset                   clock; synchronous active-high reset
//   dcr_wr_valid/addr/data       DCR write strobe, address and data
//   task_valid, task_ready       task descriptor handshake
//   task_pc, task_arg            kernel start PC and argument pointer
//   task_bid_x/y/z               block index of the current task
//   busy                         a launch is in progress (DISPATCH or DONE)
//   done                         one-cycle pulse when the launch completes
// ---------------------------------------------------------------------------
module vx_kmu_task_gen #(
   parameter logic [11:0] DCR_BASE = 12'h010,
   parameter int unsigned DIM_W    = 16
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             dcr_wr_valid,
   input  logic [11:0]      dcr_wr_addr,
   input  logic [31:0]      dcr_wr_data,

   output logic             task_valid,
   input  logic             task_ready,
   output logic [31:0]      task_pc,
   output logic [31:0]      task_arg,
   output logic [DIM_W-1:0] task_bid_x,
   output logic [DIM_W-1:0] task_bid_y,
   output logic [DIM_W-1:0] task_bid_z,

   output logic             busy,
   output logic             done
);

   localparam logic [11:0] ADDR_PC     = DCR_BASE;
   localparam logic [11:0] ADDR_ARG    = DCR_BASE + 12'd1;
   localparam logic [11:0] ADDR_GRID_X = DCR_BASE + 12'd2;
   localparam logic [11:0] ADDR_GRID_Y = DCR_BASE + 12'd3;
   localparam logic [11:0] ADDR_GRID_Z = DCR_BASE + 12'd4;
   localparam logic [11:0] ADDR_START  = DCR_BASE + 12'd5;

   localparam logic [DIM_W-1:0] ONE = {{(DIM_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DISPATCH,
      ST_DONE
   } state_t;

   state_t state;
   state_t state_next;

   // Launch configuration
   logic [31:0]      pc_q;
   logic [31:0]      arg_q;
   logic [DIM_W-1:0] grid_x_q;
   logic [DIM_W-1:0] grid_y_q;
   logic [DIM_W-1:0] grid_z_q;

   // Block index counters
   logic [DIM_W-1:0] bid_x_q;
   logic [DIM_W-1:0] bid_y_q;
   logic [DIM_W-1:0] bid_z_q;
   logic [DIM_W-1:0] bid_x_next;
   logic [DIM_W-1:0] bid_y_next;
   logic [DIM_W-1:0] bid_z_next;

   // DCR decode
   logic wr_pc;
   logic wr_arg;
   logic wr_grid_x;
   logic wr_grid_y;
   logic wr_grid_z;
   logic wr_start;

   logic in_idle;
   logic handshake;
   logic grid_ok;
   logic last_x;
   logic last_y;
   logic last_z;
   logic last_block;

   always_comb begin
      wr_pc     = dcr_wr_valid && (dcr_wr_addr == ADDR_PC);
      wr_arg    = dcr_wr_valid && (dcr_wr_addr == ADDR_ARG);
      wr_grid_x = dcr_wr_valid && (dcr_wr_addr == ADDR_GRID_X);
      wr_grid_y = dcr_wr_valid && (dcr_wr_addr == ADDR_GRID_Y);
      wr_grid_z = dcr_wr_valid && (dcr_wr_addr == ADDR_GRID_Z);
      wr_start  = dcr_wr_valid && (dcr_wr_addr == ADDR_START);
   end

   assign in_idle   = (state == ST_IDLE);
   assign handshake = task_valid && task_ready;
   assign grid_ok   = (grid_x_q != '0) && (grid_y_q != '0) && (grid_z_q != '0);

   // Wrap detection is an equality against GRID-1 computed in DIM_W bits, so
   // a full-range dimension never needs the counter to reach 2^DIM_W.
   assign last_x     = (bid_x_q == grid_x_q - ONE);
   assign last_y     = (bid_y_q == grid_y_q - ONE);
   assign last_z     = (bid_z_q == grid_z_q - ONE);
   assign last_block = last_x && last_y && last_z;

   // -----------------------------------------------------------------------
   // FSM
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (wr_start) begin
               state_next = grid_ok ? ST_DISPATCH : ST_DONE;
            end
         end
         ST_DISPATCH: begin
            if (handshake && last_block) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Configuration registers: writable only while idle, so a launch in
   // flight (including its DONE cycle) keeps its configuration.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         arg_q    <= '0;
         grid_x_q <= '0;
         grid_y_q <= '0;
         grid_z_q <= '0;
      end else if (in_idle) begin
         if (wr_pc)     pc_q     <= dcr_wr_data;
         if (wr_arg)    arg_q    <= dcr_wr_data;
         if (wr_grid_x) grid_x_q <= dcr_wr_data[DIM_W-1:0];
         if (wr_grid_y) grid_y_q <= dcr_wr_data[DIM_W-1:0];
         if (wr_grid_z) grid_z_q <= dcr_wr_data[DIM_W-1:0];
      end
   end

   // -----------------------------------------------------------------------
   // Block index counters (x fastest)
   // -----------------------------------------------------------------------
   always_comb begin
      bid_x_next = bid_x_q + ONE;
      bid_y_next = bid_y_q;
      bid_z_next = bid_z_q;
      if (last_x) begin
         bid_x_next = '0;
         bid_y_next = bid_y_q + ONE;
         if (last_y) begin
            bid_y_next = '0;
            bid_z_next = bid_z_q + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bid_x_q <= '0;
         bid_y_q <= '0;
         bid_z_q <= '0;
      end else if (in_idle && wr_start) begin
         bid_x_q <= '0;
         bid_y_q <= '0;
         bid_z_q <= '0;
      end else if (handshake) begin
         bid_x_q <= bid_x_next;
         bid_y_q <= bid_y_next;
         bid_z_q <= bid_z_next;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs: all decoded from registered state, so task_ready never reaches
   // task_valid combinationally.
   // -----------------------------------------------------------------------
   assign task_valid = (state == ST_DISPATCH);
   assign task_pc    = pc_q;
   assign task_arg   = arg_q;
   assign task_bid_x = bid_x_q;
   assign task_bid_y = bid_y_q;
   assign task_bid_z = bid_z_q;
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_vx_kmu_task_gen.sv
// ---------------------------------------------------------------------------
// tb_vx_kmu_task_gen
//
// Self-checking bench for vx_kmu_task_gen. A table of launch records (grid,
// PC, ARG, ready style, expected task count and last block index) is applied
// in a loop. Hand-written sequences cover reconfiguration during dispatch
// and reset in the middle of a launch.
// ---------------------------------------------------------------------------
module tb_vx_kmu_task_gen;

   localparam logic [11:0] BASE = 12'h010;

   logic        clk;
   logic        reset;
   logic        dcr_wr_valid;
   logic [11:0] dcr_wr_addr;
   logic [31:0] dcr_wr_data;
   logic        task_valid;
   logic        task_ready;
   logic [31:0] task_pc;
   logic [31:0] task_arg;
   logic [15:0] task_bid_x;
   logic [15:0] task_bid_y;
   logic [15:0] task_bid_z;
   logic        busy;
   logic        done;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   vx_kmu_task_gen #(
      .DCR_BASE (BASE),
      .DIM_W    (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .dcr_wr_valid (dcr_wr_valid),
      .dcr_wr_addr  (dcr_wr_addr),
      .dcr_wr_data  (dcr_wr_data),
      .task_valid   (task_valid),
      .task_ready   (task_ready),
      .task_pc      (task_pc),
      .task_arg     (task_arg),
      .task_bid_x   (task_bid_x),
      .task_bid_y   (task_bid_y),
      .task_bid_z   (task_bid_z),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] gx;
      logic [15:0] gy;
      logic [15:0] gz;
      logic [31:0] pc;
      logic [31:0] arg;
      bit          rnd;        // random task_ready instead of always-ready
      int unsigned exp_tasks;
      logic [15:0] lx;         // expected block index of the final task
      logic [15:0] ly;
      logic [15:0] lz;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dcr_write(input logic [11:0] addr, input logic [31:0] data);
      dcr_wr_valid = 1'b1;
      dcr_wr_addr  = addr;
      dcr_wr_data  = data;
      tick();
      dcr_wr_valid = 1'b0;
   endtask

   task automatic write_cfg(input vec_t v);
      dcr_write(BASE + 12'd0, v.pc);
      dcr_write(BASE + 12'd1, v.arg);
      dcr_write(BASE + 12'd2, {16'h0, v.gx});
      dcr_write(BASE + 12'd3, {16'h0, v.gy});
      dcr_write(BASE + 12'd4, {16'h0, v.gz});
   endtask

   // Issues START (optionally after programming the configuration), then
   // drains the launch while checking every task against an x-fastest walk.
   task automatic run_launch(input vec_t v, input bit do_cfg, input string tag);
      int          ex = 0, ey = 0, ez = 0;
      int          tasks = 0;
      int          done_at = -1;
      int          budget;
      bit          stalled = 1'b0;
      bit          rdy;
      logic [15:0] lx = '0, ly = '0, lz = '0;
      logic [31:0] p_pc = '0;
      logic [15:0] p_x = '0, p_y = '0, p_z = '0;

      budget = v.rnd ? int'(v.exp_tasks) * 4 + 20 : int'(v.exp_tasks) + 20;
      if (do_cfg) write_cfg(v);
      task_ready = 1'b0;
      dcr_write(BASE + 12'd5, 32'h0);

      for (int cyc = 0; cyc < budget && done_at < 0; cyc++) begin
         if (stalled) begin
            chk({tag, " stall_valid"}, 64'(task_valid), 64'(1));
            chk({tag, " stall_pc"},    64'(task_pc),    64'(p_pc));
            chk({tag, " stall_bid_x"}, 64'(task_bid_x), 64'(p_x));
            chk({tag, " stall_bid_y"}, 64'(task_bid_y), 64'(p_y));
            chk({tag, " stall_bid_z"}, 64'(task_bid_z), 64'(p_z));
         end
         if (done) begin
            done_at    = cyc;
            task_ready = 1'b0;
         end else if (task_valid) begin
            rdy        = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            task_ready = rdy;
            if (rdy) begin
               chk($sformatf("%s t%0d bid_x", tag, tasks), 64'(task_bid_x), 64'(ex));
               chk($sformatf("%s t%0d bid_y", tag, tasks), 64'(task_bid_y), 64'(ey));
               chk($sformatf("%s t%0d bid_z", tag, tasks), 64'(task_bid_z), 64'(ez));
               chk($sformatf("%s t%0d pc", tag, tasks),    64'(task_pc),    64'(v.pc));
               chk($sformatf("%s t%0d arg", tag, tasks),   64'(task_arg),   64'(v.arg));
               lx = task_bid_x;
               ly = task_bid_y;
               lz = task_bid_z;
               tasks++;
               stalled = 1'b0;
               if (ex == int'(v.gx) - 1) begin
                  ex = 0;
                  if (ey == int'(v.gy) - 1) begin
                     ey = 0;
                     ez++;
                  end else begin
                     ey++;
                  end
               end else begin
                  ex++;
               end
            end else begin
               stalled = 1'b1;
               p_pc = task_pc;
               p_x  = task_bid_x;
               p_y  = task_bid_y;
               p_z  = task_bid_z;
            end
         end else begin
            task_ready = 1'b0;
            stalled    = 1'b0;
         end
         tick();
      end
      task_ready = 1'b0;

      chk({tag, " done_seen"}, 64'(done_at >= 0), 64'(1));
      chk({tag, " task_count"}, 64'(tasks), 64'(v.exp_tasks));
      if (v.exp_tasks > 0) begin
         chk({tag, " last_x"}, 64'(lx), 64'(v.lx));
         chk({tag, " last_y"}, 64'(ly), 64'(v.ly));
         chk({tag, " last_z"}, 64'(lz), 64'(v.lz));
      end
      if (!v.rnd) begin
         chk({tag, " done_cycle"}, 64'(done_at), 64'(v.exp_tasks));
      end
      // One cycle after the done pulse
      chk({tag, " post_done"},  64'(done),       64'(0));
      chk({tag, " post_busy"},  64'(busy),       64'(0));
      chk({tag, " post_valid"}, 64'(task_valid), 64'(0));
   endtask

   vec_t vecs[6];

   initial begin
      vec_t v;
      int   n_task;
      int   n_done;

      //            gx        gy     gz     pc            arg           rnd   tasks  lx        ly     lz
      vecs[0] = '{16'd2,    16'd2, 16'd1, 32'h8000_0000, 32'h0000_1000, 1'b0, 4,     16'd1,    16'd1, 16'd0};
      vecs[1] = '{16'd3,    16'd1, 16'd2, 32'h0000_4000, 32'h0000_2000, 1'b1, 6,     16'd2,    16'd0, 16'd1};
      vecs[2] = '{16'd2,    16'd0, 16'd3, 32'h0000_5000, 32'h0000_3000, 1'b0, 0,     16'd0,    16'd0, 16'd0};
      vecs[3] = '{16'd1,    16'd3, 16'd2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 6,     16'd0,    16'd2, 16'd1};
      vecs[4] = '{16'd1,    16'd1, 16'd1, 32'hCAFE_0000, 32'h0000_0044, 1'b0, 1,     16'd0,    16'd0, 16'd0};
      vecs[5] = '{16'hFFFF, 16'd1, 16'd1, 32'h0000_0100, 32'h0000_0200, 1'b0, 65535, 16'hFFFE, 16'd0, 16'd0};

      reset        = 1'b1;
      dcr_wr_valid = 1'b0;
      dcr_wr_addr  = '0;
      dcr_wr_data  = '0;
      task_ready   = 1'b0;
      tick();
      tick();
      chk("rst valid", 64'(task_valid), 64'(0));
      chk("rst busy",  64'(busy),       64'(0));
      chk("rst done",  64'(done),       64'(0));
      chk("rst pc",    64'(task_pc),    64'(0));
      chk("rst arg",   64'(task_arg),   64'(0));
      chk("rst bid",   64'({task_bid_x, task_bid_y, task_bid_z}), 64'(0));
      reset = 1'b0;
      tick();

      // START straight out of reset: grid is zero, so no task, DONE at once
      dcr_write(BASE + 12'd5, 32'hFFFF_FFFF);
      chk("zero_grid valid", 64'(task_valid), 64'(0));
      chk("zero_grid done",  64'(done),       64'(1));
      tick();
      chk("zero_grid idle",  64'(busy),       64'(0));

      // Address just past START is not a slot
      dcr_write(BASE + 12'd6, 32'h0);
      chk("bad_addr busy", 64'(busy), 64'(0));

      for (int i = 0; i < 6; i++) begin
         run_launch(vecs[i], 1'b1, $sformatf("vec%0d", i));
      end

      // Reconfiguration and a second START during dispatch are dropped
      v = '{16'd2, 16'd1, 16'd1, 32'h0000_0100, 32'h0000_0200, 1'b0, 2, 16'd1, 16'd0, 16'd0};
      write_cfg(v);
      dcr_write(BASE + 12'd5, 32'h0);
      chk("midcfg valid0", 64'(task_valid), 64'(1));
      dcr_write(BASE + 12'd0, 32'h0000_DEAD);
      dcr_write(BASE + 12'd5, 32'h0);
      dcr_write(BASE + 12'd2, 32'd5);
      chk("midcfg valid1", 64'(task_valid), 64'(1));
      chk("midcfg pc",     64'(task_pc),    64'(32'h100));
      chk("midcfg bid_x",  64'(task_bid_x), 64'(0));
      n_task = 0;
      n_done = 0;
      task_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (task_valid) begin
            chk($sformatf("midcfg t%0d pc", n_task), 64'(task_pc), 64'(32'h100));
            n_task++;
         end
         if (done) n_done++;
         tick();
      end
      task_ready = 1'b0;
      chk("midcfg tasks", 64'(n_task), 64'(2));
      chk("midcfg dones", 64'(n_done), 64'(1));
      // Registers must still hold the original launch configuration
      run_launch(v, 1'b0, "relaunch");

      // Reset while a task is pending
      v = '{16'd2, 16'd2, 16'd2, 32'h0000_7000, 32'h0000_0070, 1'b0, 8, 16'd1, 16'd1, 16'd1};
      write_cfg(v);
      dcr_write(BASE + 12'd5, 32'h0);
      tick();
      chk("rstmid valid_before", 64'(task_valid), 64'(1));
      reset = 1'b1;
      tick();
      chk("rstmid valid", 64'(task_valid), 64'(0));
      chk("rstmid busy",  64'(busy),       64'(0));
      chk("rstmid done",  64'(done),       64'(0));
      chk("rstmid pc",    64'(task_pc),    64'(0));
      reset = 1'b0;
      tick();
      run_launch(vecs[4], 1'b1, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
